// File: rtl/audio_pll_supervisor.sv
// Audio PLL supervisor: sequences PLL reset, lock acquisition and lock
// qualification, and holds the audio datapath in reset until lock is proven.
module audio_pll_supervisor #(
  parameter int unsigned RST_HOLD_CYCLES     = 100,
  parameter int unsigned LOCK_TIMEOUT_CYCLES = 50000,
  parameter int unsigned LOCK_STABLE_CYCLES  = 1024,
  parameter int unsigned SYNC_STAGES         = 2
) (
  input  logic       refclk,
  input  logic       rst,
  input  logic       pll_locked,
  input  logic       sw_restart,
  output logic       pll_rst,
  output logic       audio_rst,
  output logic       ready,
  output logic [1:0] state,
  output logic [7:0] lock_loss_count,
  output logic [7:0] timeout_count
);

  localparam int unsigned MAX_HT = (RST_HOLD_CYCLES > LOCK_TIMEOUT_CYCLES) ?
                                   RST_HOLD_CYCLES : LOCK_TIMEOUT_CYCLES;
  localparam int unsigned MAX_P  = (MAX_HT > LOCK_STABLE_CYCLES) ? MAX_HT : LOCK_STABLE_CYCLES;
  localparam int unsigned CNT_W  = $clog2(MAX_P) + 1;

  localparam logic [1:0] RESET_PLL = 2'd0;
  localparam logic [1:0] WAIT_LOCK = 2'd1;
  localparam logic [1:0] STABILIZE = 2'd2;
  localparam logic [1:0] RUN       = 2'd3;

  localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(RST_HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(LOCK_STABLE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   locked_s;
  logic [CNT_W-1:0]       cnt;
  logic [1:0]             state_nxt;
  logic                   cnt_clr;
  logic                   timeout_inc;
  logic                   loss_inc;

  // Lock synchronizer; the FSM only ever sees its last stage.
  always_ff @(posedge refclk) begin
    if (rst) sync_q <= '0;
    else     sync_q <= {sync_q[SYNC_STAGES-2:0], pll_locked};
  end

  assign locked_s = sync_q[SYNC_STAGES-1];

  // Next-state decode; a software restart overrides everything, including fault counting.
  always_comb begin
    state_nxt   = state;
    timeout_inc = 1'b0;
    loss_inc    = 1'b0;
    if (sw_restart) begin
      state_nxt = RESET_PLL;
    end else begin
      case (state)
        RESET_PLL: if (cnt == HOLD_LAST) state_nxt = WAIT_LOCK;
        WAIT_LOCK: begin
          if (locked_s) begin
            state_nxt = STABILIZE;
          end else if (cnt == TIMEOUT_LAST) begin
            state_nxt   = RESET_PLL;
            timeout_inc = 1'b1;
          end
        end
        STABILIZE: begin
          if (!locked_s)                state_nxt = WAIT_LOCK;
          else if (cnt == STABLE_LAST)  state_nxt = RUN;
        end
        RUN: begin
          if (!locked_s) begin
            state_nxt = RESET_PLL;
            loss_inc  = 1'b1;
          end
        end
        default: state_nxt = RESET_PLL;
      endcase
    end
    cnt_clr = sw_restart || (state_nxt != state);
  end

  // State, dwell counter, registered output decode and saturating fault counters.
  always_ff @(posedge refclk) begin
    if (rst) begin
      state           <= RESET_PLL;
      cnt             <= '0;
      pll_rst         <= 1'b1;
      audio_rst       <= 1'b1;
      ready           <= 1'b0;
      lock_loss_count <= 8'd0;
      timeout_count   <= 8'd0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_clr ? '0 : cnt + CNT_W'(1);
      pll_rst   <= (state_nxt == RESET_PLL);
      audio_rst <= (state_nxt != RUN);
      ready     <= (state_nxt == RUN);
      if (timeout_inc && (timeout_count != 8'hFF))
        timeout_count <= timeout_count + 8'd1;
      if (loss_inc && (lock_loss_count != 8'hFF))
        lock_loss_count <= lock_loss_count + 8'd1;
    end
  end

endmodule

// File: tb/tb_audio_pll_supervisor.sv
// Bench for audio_pll_supervisor: directed scenarios plus random lock/restart
// traffic, checked every cycle against a time-stamp based reference model.
module tb_audio_pll_supervisor;

  localparam int HOLD = 4;
  localparam int TMO  = 20;
  localparam int STB  = 8;
  localparam int SYNC = 2;

  logic       refclk = 1'b0;
  logic       rst;
  logic       pll_locked;
  logic       sw_restart;
  logic       pll_rst;
  logic       audio_rst;
  logic       ready;
  logic [1:0] state;
  logic [7:0] lock_loss_count;
  logic [7:0] timeout_count;
  logic [20:0] dut_vec;

  audio_pll_supervisor #(
    .RST_HOLD_CYCLES     (HOLD),
    .LOCK_TIMEOUT_CYCLES (TMO),
    .LOCK_STABLE_CYCLES  (STB),
    .SYNC_STAGES         (SYNC)
  ) dut (
    .refclk          (refclk),
    .rst             (rst),
    .pll_locked      (pll_locked),
    .sw_restart      (sw_restart),
    .pll_rst         (pll_rst),
    .audio_rst       (audio_rst),
    .ready           (ready),
    .state           (state),
    .lock_loss_count (lock_loss_count),
    .timeout_count   (timeout_count)
  );

  always #5 refclk = ~refclk;

  assign dut_vec = {state, pll_rst, audio_rst, ready, lock_loss_count, timeout_count};

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: state is tracked with the edge index it was entered on,
  // and the synchronizer is a plain delay line of past pll_locked samples.
  int m_state;
  int m_entry;
  int m_to;
  int m_ll;
  int cyc;
  bit m_q[$];

  task automatic model_edge(input logic r, input logic lk, input logic sw);
    int el;
    int nxt;
    bit ls;
    el = cyc - m_entry - 1;
    ls = m_q.pop_front();
    m_q.push_back(lk);
    if (r) begin
      m_state = 0;
      m_entry = cyc;
      m_to    = 0;
      m_ll    = 0;
      m_q.delete();
      repeat (SYNC) m_q.push_back(1'b0);
    end else if (sw) begin
      m_state = 0;
      m_entry = cyc;
    end else begin
      nxt = m_state;
      case (m_state)
        0: if (el == HOLD - 1) nxt = 1;
        1: begin
          if (ls) nxt = 2;
          else if (el == TMO - 1) begin
            nxt  = 0;
            m_to = (m_to < 255) ? m_to + 1 : 255;
          end
        end
        2: begin
          if (!ls) nxt = 1;
          else if (el == STB - 1) nxt = 3;
        end
        default: begin
          if (!ls) begin
            nxt  = 0;
            m_ll = (m_ll < 255) ? m_ll + 1 : 255;
          end
        end
      endcase
      if (nxt != m_state) begin
        m_state = nxt;
        m_entry = cyc;
      end
    end
    cyc++;
  endtask

  function automatic logic [20:0] model_vec();
    return {m_state[1:0], m_state == 0, m_state != 3, m_state == 3, m_ll[7:0], m_to[7:0]};
  endfunction

  task automatic step(input logic r, input logic lk, input logic sw);
    @(negedge refclk);
    rst        = r;
    pll_locked = lk;
    sw_restart = sw;
    @(posedge refclk);
    model_edge(r, lk, sw);
    #1;
    check_eq("outputs", 32'(dut_vec), 32'(model_vec()));
  endtask

  // Step with a fixed lock level until the DUT reaches a state, bounded.
  task automatic run_until(input int want, input logic lk, input int budget, output int n);
    n = 0;
    do begin
      step(1'b0, lk, 1'b0);
      n++;
    end while ((32'(state) != 32'(want)) && (n < budget));
    check_eq("reach_state", 32'(state), 32'(want));
  endtask

  initial begin
    int n;
    int seg;
    logic lk;
    logic sw;
    logic r;
    cyc = 0;
    m_state = 0; m_entry = 0; m_to = 0; m_ll = 0;
    repeat (SYNC) m_q.push_back(1'b0);
    rst = 1'b1; pll_locked = 1'b0; sw_restart = 1'b0;

    repeat (3) step(1'b1, 1'b0, 1'b0);
    check_eq("reset_vals", 32'(dut_vec), 32'({2'd0, 1'b1, 1'b1, 1'b0, 8'd0, 8'd0}));

    // Normal lock and lock loss
    run_until(1, 1'b0, 50, n);
    check_eq("hold_len", 32'(n), 32'(HOLD));
    repeat (5) step(1'b0, 1'b0, 1'b0);
    run_until(2, 1'b1, 50, n);
    check_eq("lock_latency", 32'(n), 32'(SYNC + 1));
    run_until(3, 1'b1, 50, n);
    check_eq("stable_len", 32'(n), 32'(STB));
    check_eq("run_ready", 32'({audio_rst, ready}), 32'(2'b01));
    run_until(0, 1'b0, 50, n);
    check_eq("loss_latency", 32'(n), 32'(SYNC + 1));
    check_eq("loss_count1", 32'(lock_loss_count), 32'd1);
    run_until(3, 1'b1, 100, n);

    // Lock loss coinciding with sw_restart is not counted
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1);
    check_eq("sim_state", 32'(state), 32'd0);
    check_eq("sim_loss", 32'(lock_loss_count), 32'd1);

    // sw_restart mid-hold restarts the full hold
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1);
    run_until(1, 1'b0, 20, n);
    check_eq("rehold_len", 32'(n), 32'(HOLD));

    // One-cycle lock glitch during STABILIZE
    run_until(2, 1'b1, 50, n);
    repeat (3) step(1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    run_until(3, 1'b1, 100, n);
    check_eq("glitch_to", 32'(timeout_count), 32'd0);
    check_eq("glitch_ll", 32'(lock_loss_count), 32'd1);

    // Timeout, then reset in STABILIZE with non-zero counters
    run_until(0, 1'b0, 50, n);
    run_until(1, 1'b0, 50, n);
    run_until(0, 1'b0, 50, n);
    check_eq("timeout_len", 32'(n), 32'(TMO));
    check_eq("timeout_cnt", 32'(timeout_count), 32'd1);
    run_until(2, 1'b1, 50, n);
    step(1'b1, 1'b1, 1'b0);
    check_eq("midrst_vals", 32'(dut_vec), 32'({2'd0, 1'b1, 1'b1, 1'b0, 8'd0, 8'd0}));

    // Never locks: timeout counter saturates
    repeat (300 * (HOLD + TMO)) step(1'b0, 1'b0, 1'b0);
    check_eq("timeout_sat", 32'(timeout_count), 32'd255);

    // Repeated lock losses: loss counter saturates
    step(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 260; i++) begin
      run_until(3, 1'b1, 100, n);
      run_until(0, 1'b0, 20, n);
    end
    check_eq("loss_sat", 32'(lock_loss_count), 32'd255);

    // Random lock segments, restarts and occasional resets
    step(1'b1, 1'b0, 1'b0);
    lk  = 1'b0;
    seg = 0;
    for (int i = 0; i < 4000; i++) begin
      if (seg == 0) begin
        if ($urandom_range(0, 3) != 0) lk = ~lk;
        seg = int'($urandom_range(1, 40));
      end
      seg--;
      sw = ($urandom_range(0, 79) == 0);
      r  = ($urandom_range(0, 999) == 0);
      step(r, lk, sw);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
